// File: rtl/video_out_pipe.sv
// 640x480@60 video output pipe: 320x240 native rows, 2x2 doubled,
// row RAM -> palette RAM -> rgb with 4-cycle counter-to-pixel latency.
// Ports:
//   clk, rst_n (async, active-low)
//   rram_rdaddr/rram_rddata: row RAM (index per native column)
//   pram_rdaddr/pram_rddata: palette RAM (24-bit colour in [23:0])
//   row_req/row_num: request to the renderer to fill the next native row
//   hsync, vsync (active-low), de, rgb: display outputs
//   test_pattern: colour-bar override, present only when
//   VIDEO_OUT_TEST_PATTERN_EN is defined
module video_out_pipe (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VIDEO_OUT_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [8:0]  rram_rdaddr,
  input  logic [9:0]  rram_rddata,
  output logic [9:0]  pram_rdaddr,
  input  logic [31:0] pram_rddata,
  output logic        row_req,
  output logic [7:0]  row_num,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb
);

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [8:0]  rdaddr_q, rdaddr_d;
  logic [9:0]  pidx_q;
  logic [2:0]  vis_q, hs_q, vs_q;
  logic        de_q, hsync_q, vsync_q;
  logic [23:0] rgb_q, rgb_d;
  logic        req_q, req_d;
  logic [7:0]  num_q, num_d;
  logic        vis0, hs0, vs0;
  logic        req_row;
  logic        unused_hi;

  assign unused_hi = ^pram_rddata[31:24];

  always_comb begin
    h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'd799)
      v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
  end

  assign vis0 = (h_q < 10'd640) && (v_q < 10'd480);
  assign hs0  = !((h_q >= 10'd656) && (h_q <= 10'd751));
  assign vs0  = !((v_q >= 10'd490) && (v_q <= 10'd491));

  // Address and row request come from the next-state counters so
  // they line up with h_q; this buys back one cycle of RAM latency.
  always_comb begin
    rdaddr_d = (h_d < 10'd640) ? h_d[9:1] : 9'd0;
    req_row  = !v_d[0] &&
               ((v_d <= 10'd476) || (v_d == 10'd524));
    req_d    = (h_d == 10'd640) && req_row;
    num_d    = 8'd0;
    if (req_d && (v_d != 10'd524))
      num_d = v_d[8:1] + 8'd1;
  end

`ifdef VIDEO_OUT_TEST_PATTERN_EN
  logic [2:0] bar0;
  logic [2:0] bar_q [3];

  always_comb begin
    bar0 = 3'd7;
    if (h_q < 10'd560) bar0 = 3'd6;
    if (h_q < 10'd480) bar0 = 3'd5;
    if (h_q < 10'd400) bar0 = 3'd4;
    if (h_q < 10'd320) bar0 = 3'd3;
    if (h_q < 10'd240) bar0 = 3'd2;
    if (h_q < 10'd160) bar0 = 3'd1;
    if (h_q < 10'd80)  bar0 = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q[0] <= 3'd0;
      bar_q[1] <= 3'd0;
      bar_q[2] <= 3'd0;
    end else begin
      bar_q[0] <= bar0;
      bar_q[1] <= bar_q[0];
      bar_q[2] <= bar_q[1];
    end
  end

  always_comb begin
    rgb_d = pram_rddata[23:0];
    if (test_pattern) begin
      unique case (bar_q[2])
        3'd0:    rgb_d = 24'hFFFFFF;
        3'd1:    rgb_d = 24'hFFFF00;
        3'd2:    rgb_d = 24'h00FFFF;
        3'd3:    rgb_d = 24'h00FF00;
        3'd4:    rgb_d = 24'hFF00FF;
        3'd5:    rgb_d = 24'hFF0000;
        3'd6:    rgb_d = 24'h0000FF;
        default: rgb_d = 24'h000000;
      endcase
    end
    if (!vis_q[2])
      rgb_d = 24'h000000;
  end
`else
  always_comb begin
    rgb_d = vis_q[2] ? pram_rddata[23:0] : 24'h000000;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      rdaddr_q <= 9'd0;
      pidx_q   <= 10'd0;
      vis_q    <= 3'b000;
      hs_q     <= 3'b111;
      vs_q     <= 3'b111;
      de_q     <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= 24'h000000;
      req_q    <= 1'b0;
      num_q    <= 8'd0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      rdaddr_q <= rdaddr_d;
      pidx_q   <= rram_rddata;
      vis_q    <= {vis_q[1:0], vis0};
      hs_q     <= {hs_q[1:0], hs0};
      vs_q     <= {vs_q[1:0], vs0};
      de_q     <= vis_q[2];
      hsync_q  <= hs_q[2];
      vsync_q  <= vs_q[2];
      rgb_q    <= rgb_d;
      req_q    <= req_d;
      num_q    <= num_d;
    end
  end

  assign rram_rdaddr = rdaddr_q;
  assign pram_rdaddr = pidx_q;
  assign row_req     = req_q;
  assign row_num     = num_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_video_out_pipe.sv
// Self-checking bench for video_out_pipe: random row/palette contents,
// timing model from frame geometry, mid-frame reset.
module tb_video_out_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tp = 1'b0;
  logic [8:0]  rram_rdaddr;
  logic [9:0]  rram_rddata;
  logic [9:0]  pram_rdaddr;
  logic [31:0] pram_rddata;
  logic        row_req;
  logic [7:0]  row_num;
  logic        hsync, vsync, de;
  logic [23:0] rgb;

  logic [31:0] ptbl [1024];
  logic [23:0] bars [8];
  int salt;
  int checks = 0;
  int failures = 0;
  int k;
  int loaded, pend, pend_cnt;

  int mc, mh, mv, hk, vk;
  logic ede, ehs, evs, ereq;
  logic [23:0] ergb;
  logic [8:0] eaddr;
  logic [7:0] enum_;
  int de_run, hs_run;
  logic hs_prev;

  always #20 clk = ~clk;

  video_out_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VIDEO_OUT_TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .rram_rdaddr(rram_rdaddr),
    .rram_rddata(rram_rddata),
    .pram_rdaddr(pram_rdaddr),
    .pram_rddata(pram_rddata),
    .row_req(row_req),
    .row_num(row_num),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb)
  );

  function automatic logic [9:0] rowpix(input int r, input int c);
    int x;
    x = r * 37 + c * 13 + salt;
    return x[9:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Renderer + RAMs: a requested row becomes readable once the
  // displayed line pair of the previous row has been read out.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded      <= 0;
      pend        <= 0;
      pend_cnt    <= 0;
      rram_rddata <= '0;
      pram_rddata <= '0;
    end else begin
      if (row_req) begin
        pend     <= int'(row_num);
        pend_cnt <= 900;
      end else if (pend_cnt == 1) begin
        loaded   <= pend;
        pend_cnt <= 0;
      end else if (pend_cnt > 1) begin
        pend_cnt <= pend_cnt - 1;
      end
      rram_rddata <= rowpix(loaded, int'(rram_rdaddr));
      pram_rddata <= ptbl[pram_rdaddr];
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      de_run  = 0;
      hs_run  = 0;
      hs_prev = 1'b1;
    end else begin
      hk    = k % 800;
      vk    = (k / 800) % 525;
      eaddr = (hk < 640) ? 9'(hk / 2) : 9'd0;
      ereq  = (hk == 640) && (vk % 2 == 0) &&
              ((vk <= 476) || (vk == 524));
      enum_ = (vk == 524) ? 8'd0 : 8'(vk / 2 + 1);
      ede   = 1'b0;
      ehs   = 1'b1;
      evs   = 1'b1;
      ergb  = 24'h0;
      if (k >= 4) begin
        mc  = k - 4;
        mh  = mc % 800;
        mv  = (mc / 800) % 525;
        ede = (mh < 640) && (mv < 480);
        ehs = !((mh >= 656) && (mh <= 751));
        evs = !((mv >= 490) && (mv <= 491));
        if (ede)
          ergb = tp ? bars[mh / 80]
                    : ptbl[rowpix(mv / 2, mh / 2)][23:0];
      end
      chk("de", 32'(de), 32'(ede));
      chk("hsync", 32'(hsync), 32'(ehs));
      chk("vsync", 32'(vsync), 32'(evs));
      chk("rgb", 32'(rgb), 32'(ergb));
      chk("rram_rdaddr", 32'(rram_rdaddr), 32'(eaddr));
      chk("row_req", 32'(row_req), 32'(ereq));
      if (ereq) chk("row_num", 32'(row_num), 32'(enum_));

      if (k == 3)    chk("de_k3", 32'(de), 0);
      if (k == 4)    chk("de_first", 32'(de), 1);
      if (k == 643)  chk("de_last", 32'(de), 1);
      if (k == 644)  chk("de_off", 32'(de), 0);
      if (k == 659)  chk("hs_k659", 32'(hsync), 1);
      if (k == 660)  chk("hs_k660", 32'(hsync), 0);
      if (k == 640)  chk("rreq_v0", 32'(row_req), 1);
      if (k == 640)  chk("rnum_v0", 32'(row_num), 1);
      if (k == 1440) chk("rreq_v1", 32'(row_req), 0);
      if (k == 2240) chk("rnum_v2", 32'(row_num), 2);
      if (k == 84 && tp) chk("bar1", 32'(rgb), 32'h00FFFF00);
      if (k == 4 && tp)  chk("bar0", 32'(rgb), 32'h00FFFFFF);

      if (de) de_run++;
      else begin
        if (de_run != 0) chk("de_run", de_run, 640);
        de_run = 0;
      end
      if (!hsync) begin
        if (hs_prev) chk("hs_start", k % 800, 660);
        hs_run++;
      end else begin
        if (!hs_prev) chk("hs_len", hs_run, 96);
        hs_run = 0;
      end
      hs_prev = hsync;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_de", 32'(de), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_rram", 32'(rram_rdaddr), 0);
    chk("rst_pram", 32'(pram_rdaddr), 0);
    chk("rst_req", 32'(row_req), 0);
    chk("rst_num", 32'(row_num), 0);
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00;
    bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000;
    bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    salt = int'($urandom_range(0, 1023));
    for (int i = 0; i < 1024; i++) ptbl[i] = $urandom;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 20000 && k != 16300; i++) @(negedge clk);
    chk("reach_mid", k, 16300);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    chk_reset_vals();
`ifdef VIDEO_OUT_TEST_PATTERN_EN
    tp = 1'b1;
`endif
    #2 rst_n = 1'b1;
    repeat (30000) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
